// File: rtl/cond_exec_stage_if.sv
// Decode/EX boundary bundle for cond_exec_stage: D-stage controls in, gated EX controls and flags out.
// With CONDEX_PERF_CNT_EN defined, the executed/squashed instruction counters are carried here too.
interface cond_exec_stage_if;
  logic [3:0]  CondD;
  logic [1:0]  FlagWD;
  logic        PCSD;
  logic        RegWD;
  logic        MemWD;
  logic        MemtoRegD;
  logic        ALUSrcD;
  logic        NoWriteD;
  logic [2:0]  ALUControlD;
  logic        StallE;
  logic        FlushE;
  logic [3:0]  ALUFlags;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic        MemtoRegE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        PCSrcE;
  logic        CondExE;
  logic [3:0]  Flags;
`ifdef CONDEX_PERF_CNT_EN
  logic [31:0] ExecCnt;
  logic [31:0] SquashCnt;
`endif

  modport master (
    output CondD, FlagWD, PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, NoWriteD, ALUControlD,
    output StallE, FlushE, ALUFlags,
`ifdef CONDEX_PERF_CNT_EN
    input  ExecCnt, SquashCnt,
`endif
    input  ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE, CondExE, Flags
  );

  modport slave (
    input  CondD, FlagWD, PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, NoWriteD, ALUControlD,
    input  StallE, FlushE, ALUFlags,
`ifdef CONDEX_PERF_CNT_EN
    output ExecCnt, SquashCnt,
`endif
    output ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE, CondExE, Flags
  );
endinterface

// File: rtl/cond_exec_stage.sv
// D->EX pipeline register with NZCV flags and ARM condition evaluation; 1-cycle D->E, gated outputs combinational.
// StallE holds EX and freezes flags, FlushE/taken branch load a bubble; CONDEX_PERF_CNT_EN adds Exec/Squash counters.
module cond_exec_stage (
  input  logic           clk,
  input  logic           rst_n,
  cond_exec_stage_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       nowrite;
    logic [2:0] aluctl;
  } ex_t;

  ex_t        ex_q, ex_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_pass;
  logic       cond_ex;
  logic       pcsrc;
  logic       fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (ex_q.cond)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = ~fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = ~fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = ~fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = ~fv;
      4'b1000: cond_pass = fc & ~fz;
      4'b1001: cond_pass = ~fc | fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = ~fz & (fn == fv);
      4'b1101: cond_pass = fz | (fn != fv);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex = ex_q.valid & cond_pass;
  assign pcsrc   = ex_q.pcs & cond_ex;

  assign bus.ALUControlE = ex_q.aluctl;
  assign bus.ALUSrcE     = ex_q.alusrc;
  assign bus.MemtoRegE   = ex_q.memtoreg;
  assign bus.RegWriteE   = ex_q.regw & cond_ex & ~ex_q.nowrite;
  assign bus.MemWriteE   = ex_q.memw & cond_ex;
  assign bus.PCSrcE      = pcsrc;
  assign bus.CondExE     = cond_ex;
  assign bus.Flags       = flags_q;

  // A taken branch squashes the wrong-path D instruction even when EX is stalled.
  always_comb begin
    ex_d = ex_q;
    if (bus.FlushE || pcsrc) begin
      ex_d = '0;
    end else if (!bus.StallE) begin
      ex_d.valid    = 1'b1;
      ex_d.cond     = bus.CondD;
      ex_d.flagw    = bus.FlagWD;
      ex_d.pcs      = bus.PCSD;
      ex_d.regw     = bus.RegWD;
      ex_d.memw     = bus.MemWD;
      ex_d.memtoreg = bus.MemtoRegD;
      ex_d.alusrc   = bus.ALUSrcD;
      ex_d.nowrite  = bus.NoWriteD;
      ex_d.aluctl   = bus.ALUControlD;
    end
  end

  // Flush only affects the incoming slot; the instruction already in EX still retires its flags.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && !bus.StallE) begin
      if (ex_q.flagw[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (ex_q.flagw[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      flags_q <= 4'b0000;
    end else begin
      ex_q    <= ex_d;
      flags_q <= flags_d;
    end
  end

`ifdef CONDEX_PERF_CNT_EN
  logic [31:0] exec_cnt_q, exec_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (!bus.StallE) begin
      if (cond_ex)                   exec_cnt_d   = exec_cnt_q + 32'd1;
      if (ex_q.valid && !cond_pass)  squash_cnt_d = squash_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.ExecCnt   = exec_cnt_q;
  assign bus.SquashCnt = squash_cnt_q;
`endif

endmodule
